// File: rtl/bht_defines.sv
// Shared definitions for the branch history table: counter states and default widths.
package bht_defines;

    localparam int unsigned IM_ADDR_BIT_DEF = 10;
    localparam int unsigned ENTRY_BIT_DEF   = 4;
    localparam int unsigned STAT_BIT_DEF    = 16;

    typedef enum logic [1:0] {
        BHT_SNT = 2'd0,
        BHT_WNT = 2'd1,
        BHT_WT  = 2'd2,
        BHT_ST  = 2'd3
    } bht_ctr_t;

    localparam bht_ctr_t BHT_ALLOC = BHT_WT;

endpackage

// File: rtl/cmb_sat_counter2.sv
// Combinational next state of a 2-bit saturating branch counter.
module cmb_sat_counter2
    import bht_defines::*;
(
    input  bht_ctr_t cur,
    input  logic     taken,
    output bht_ctr_t nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/syn_bht_predictor.sv
// Direct-mapped tagged branch history table producing the ps0 next-PC guess,
// trained by ps3 resolution writes, with saturating branch/mispredict statistics.
module syn_bht_predictor
    import bht_defines::*;
#(
    parameter int unsigned IM_ADDR_BIT = IM_ADDR_BIT_DEF,
    parameter int unsigned ENTRY_BIT   = ENTRY_BIT_DEF,
    parameter int unsigned STAT_BIT    = STAT_BIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [IM_ADDR_BIT-1:0] pc,
    output logic [IM_ADDR_BIT-1:0] pc_guessed,
    output logic                   pred_hit,
    output logic                   pred_taken,
    input  logic                   upd_valid,
    input  logic [IM_ADDR_BIT-1:0] upd_pc,
    input  logic                   upd_taken,
    input  logic [IM_ADDR_BIT-1:0] upd_target,
    input  logic                   upd_mispred,
    output logic [STAT_BIT-1:0]    stat_branches,
    output logic [STAT_BIT-1:0]    stat_mispred
);

    localparam int unsigned ENTRIES = 1 << ENTRY_BIT;
    localparam int unsigned TAG_W   = IM_ADDR_BIT - ENTRY_BIT;

    logic [ENTRIES-1:0]     valid_q;
    logic [TAG_W-1:0]       tag_q    [ENTRIES];
    bht_ctr_t               ctr_q    [ENTRIES];
    logic [IM_ADDR_BIT-1:0] target_q [ENTRIES];
    logic [STAT_BIT-1:0]    stat_br_q;
    logic [STAT_BIT-1:0]    stat_mp_q;

    logic [ENTRY_BIT-1:0]   rd_idx;
    logic [TAG_W-1:0]       rd_tag;
    logic [ENTRY_BIT-1:0]   upd_idx;
    logic [TAG_W-1:0]       upd_tag;
    logic                   upd_hit;
    logic                   upd_acc;
    bht_ctr_t               ctr_nxt;

    always_comb begin
        rd_idx     = pc[ENTRY_BIT-1:0];
        rd_tag     = pc[IM_ADDR_BIT-1:ENTRY_BIT];
        pred_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken = pred_hit && (ctr_q[rd_idx] >= BHT_WT);
        pc_guessed = pred_taken ? target_q[rd_idx] : pc + IM_ADDR_BIT'(1);
    end

    always_comb begin
        upd_idx = upd_pc[ENTRY_BIT-1:0];
        upd_tag = upd_pc[IM_ADDR_BIT-1:ENTRY_BIT];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_acc = upd_valid && en;
    end

    cmb_sat_counter2 u_ctr_next (
        .cur   (ctr_q[upd_idx]),
        .taken (upd_taken),
        .nxt   (ctr_nxt)
    );

    // Tags and targets are left unreset; valid bits alone gate the lookup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_SNT;
            end
        end else if (upd_acc) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_nxt;
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                ctr_q[upd_idx]    <= BHT_ALLOC;
                target_q[upd_idx] <= upd_target;
            end
            if (stat_br_q != '1) begin
                stat_br_q <= stat_br_q + STAT_BIT'(1);
            end
            if (upd_mispred && (stat_mp_q != '1)) begin
                stat_mp_q <= stat_mp_q + STAT_BIT'(1);
            end
        end
    end

    always_comb begin
        stat_branches = stat_br_q;
        stat_mispred  = stat_mp_q;
    end

endmodule

// File: tb/tb_syn_bht_predictor.sv
// Directed and randomized checks of syn_bht_predictor against a behavioural table model.
module tb_syn_bht_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [9:0]  pc;
    logic [9:0]  pc_guessed;
    logic        pred_hit;
    logic        pred_taken;
    logic        upd_valid;
    logic [9:0]  upd_pc;
    logic        upd_taken;
    logic [9:0]  upd_target;
    logic        upd_mispred;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Behavioural model: plain integers, one record per table slot.
    bit m_valid [16];
    int m_tag   [16];
    int m_ctr   [16];
    int m_tgt   [16];
    int m_br;
    int m_mp;

    always #5 clk = ~clk;

    syn_bht_predictor #(
        .IM_ADDR_BIT (10),
        .ENTRY_BIT   (4),
        .STAT_BIT    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pc            (pc),
        .pc_guessed    (pc_guessed),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispred   (upd_mispred),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_edge();
        int idx, tg;
        bit hit;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 0;
            end
            m_br = 0;
            m_mp = 0;
        end else if (upd_valid && en) begin
            idx = int'(upd_pc) % 16;
            tg  = int'(upd_pc) / 16;
            hit = m_valid[idx] && (m_tag[idx] == tg);
            if (hit && upd_taken) begin
                m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                m_tgt[idx] = int'(upd_target);
            end else if (hit) begin
                m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            end else if (upd_taken) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_ctr[idx]   = 2;
                m_tgt[idx]   = int'(upd_target);
            end
            if (m_br < 65535) m_br++;
            if (upd_mispred && m_mp < 65535) m_mp++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string name);
        int idx;
        bit hit, tk;
        int guess;
        #1;
        idx   = int'(pc) % 16;
        hit   = m_valid[idx] && (m_tag[idx] == int'(pc) / 16);
        tk    = hit && (m_ctr[idx] >= 2);
        guess = tk ? m_tgt[idx] : (int'(pc) + 1) % 1024;
        chk({name, ".hit"},   32'(pred_hit),      32'(hit));
        chk({name, ".taken"}, 32'(pred_taken),    32'(tk));
        chk({name, ".guess"}, 32'(pc_guessed),    32'(guess));
        chk({name, ".br"},    32'(stat_branches), 32'(m_br));
        chk({name, ".mp"},    32'(stat_mispred),  32'(m_mp));
    endtask

    task automatic upd(input logic [9:0] a, input logic t, input logic [9:0] tgt, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = a;
        upd_taken   = t;
        upd_target  = tgt;
        upd_mispred = mp;
        tick();
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
        #1;
        tick(); tick();
        rst_n = 1'b1;
        pc = 10'h040;
        #1;
        chk("rst.guess",  32'(pc_guessed), 32'h041);
        chk("rst.hit",    32'(pred_hit), 0);
        chk("rst.taken",  32'(pred_taken), 0);
        chk("rst.br",     32'(stat_branches), 0);
        chk("rst.mp",     32'(stat_mispred), 0);

        // Allocation: same-cycle lookup still sees the old contents.
        upd_valid = 1'b1; upd_pc = 10'h040; upd_taken = 1'b1; upd_target = 10'h020; upd_mispred = 1'b1;
        #1;
        chk("alloc.same_cycle", 32'(pc_guessed), 32'h041);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("alloc.hit",   32'(pred_hit), 1);
        chk("alloc.taken", 32'(pred_taken), 1);
        chk("alloc.guess", 32'(pc_guessed), 32'h020);
        chk("alloc.br",    32'(stat_branches), 1);
        chk("alloc.mp",    32'(stat_mispred), 1);

        // Counter walk 2->1->0->1->2->3->2.
        upd(10'h040, 1'b0, 10'h000, 1'b0);
        chk("walk.nt1.guess", 32'(pc_guessed), 32'h041);
        chk("walk.nt1.hit",   32'(pred_hit), 1);
        upd(10'h040, 1'b0, 10'h000, 1'b0);
        chk("walk.nt2.guess", 32'(pc_guessed), 32'h041);
        upd(10'h040, 1'b1, 10'h020, 1'b0);
        chk("walk.t1.guess",  32'(pc_guessed), 32'h041);
        upd(10'h040, 1'b1, 10'h020, 1'b0);
        chk("walk.t2.guess",  32'(pc_guessed), 32'h020);
        upd(10'h040, 1'b1, 10'h020, 1'b0);
        chk("walk.t3.guess",  32'(pc_guessed), 32'h020);
        upd(10'h040, 1'b0, 10'h000, 1'b0);
        chk("walk.nt3.guess", 32'(pc_guessed), 32'h020);
        chk("walk.br", 32'(stat_branches), 7);
        chk("walk.mp", 32'(stat_mispred), 1);

        // Aliasing on index 0.
        pc = 10'h050; #1;
        chk("alias.miss.hit",   32'(pred_hit), 0);
        chk("alias.miss.guess", 32'(pc_guessed), 32'h051);
        upd(10'h050, 1'b0, 10'h000, 1'b0);
        pc = 10'h040; #1;
        chk("alias.nt.keep", 32'(pc_guessed), 32'h020);
        upd(10'h050, 1'b1, 10'h100, 1'b0);
        #1;
        chk("alias.old.hit",   32'(pred_hit), 0);
        chk("alias.old.guess", 32'(pc_guessed), 32'h041);
        pc = 10'h050; #1;
        chk("alias.new.guess", 32'(pc_guessed), 32'h100);

        // Disabled update is dropped; lookup stays live.
        en = 1'b0;
        upd(10'h060, 1'b1, 10'h200, 1'b1);
        chk("gate.live", 32'(pc_guessed), 32'h100);
        en = 1'b1;
        pc = 10'h060; #1;
        chk("gate.hit", 32'(pred_hit), 0);
        chk("gate.br",  32'(stat_branches), 9);
        chk("gate.mp",  32'(stat_mispred), 1);

        // Reset beats a coincident update.
        rst_n = 1'b0;
        upd(10'h070, 1'b1, 10'h300, 1'b1);
        rst_n = 1'b1;
        pc = 10'h050; #1;
        chk("rst2.hit50",  32'(pred_hit), 0);
        chk("rst2.guess",  32'(pc_guessed), 32'h051);
        pc = 10'h070; #1;
        chk("rst2.hit70",  32'(pred_hit), 0);
        chk("rst2.br",     32'(stat_branches), 0);
        chk("rst2.mp",     32'(stat_mispred), 0);
        pc = 10'h3FF; #1;
        chk("wrap.guess",  32'(pc_guessed), 32'h000);

        // Randomized traffic on a few tags so that hits and aliasing are frequent.
        for (int n = 0; n < 1500; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            en          = ($urandom_range(0, 9) != 0);
            upd_valid   = ($urandom_range(0, 9) < 7);
            upd_pc      = {6'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            upd_taken   = 1'($urandom);
            upd_target  = 10'($urandom);
            upd_mispred = 1'($urandom);
            pc = ($urandom_range(0, 3) == 0) ? upd_pc
                 : {6'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            check_model("rand");
            tick();
        end

        // Statistics saturation.
        rst_n = 1'b0; en = 1'b1; upd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        upd_valid = 1'b1; upd_pc = 10'h123; upd_taken = 1'b0; upd_mispred = 1'b1;
        repeat (65534) tick();
        chk("sat.pre.br", 32'(stat_branches), 32'hFFFE);
        chk("sat.pre.mp", 32'(stat_mispred),  32'hFFFE);
        repeat (2) tick();
        chk("sat.full.br", 32'(stat_branches), 32'hFFFF);
        chk("sat.full.mp", 32'(stat_mispred),  32'hFFFF);
        tick();
        upd_valid = 1'b0;
        chk("sat.hold.br", 32'(stat_branches), 32'hFFFF);
        chk("sat.hold.mp", 32'(stat_mispred),  32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
